// File: rtl/spec_handler_pipe.sv
// FMA special-case handler: per-lane NaN/invalid/inf/zero/overflow/underflow detection with substitute result and sticky flags.
// Two register stages, in to out; a stalled output holds both stages and drops in_ready only when both are full.
module spec_handler_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int LANES     = 4,
    parameter int NAN_QUIET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             nj_mode,
    input  logic [LANES-1:0]                 inv_mask,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] operand_a,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] operand_b,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] operand_c,
    input  logic [LANES*(EXP_W+1)-1:0]       exp_ab,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0]                 spec_mask,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0] res_spec,
    input  logic                             flag_clr,
    output logic                             flag_invalid,
    output logic                             flag_overflow,
    output logic                             flag_underflow
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMAX = EW'(BIAS);
    localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } cls_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        cls_t         ca;
        cls_t         cb;
        cls_t         cc;
        logic         ovf;
        logic         unf;
        logic         inv;
    } lane_t;

    typedef struct packed {
        logic         sp;
        logic [W-1:0] res;
        logic         iv;
        logic         ov;
        logic         un;
    } sel_t;

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t k;
        logic exp_zero;
        logic exp_ones;
        logic man_zero;
        exp_zero = (x[W-2:MAN_W] == '0);
        exp_ones = &x[W-2:MAN_W];
        man_zero = (x[MAN_W-1:0] == '0);
        k.zero = exp_zero && man_zero;
        k.inf  = exp_ones && man_zero;
        k.nan  = exp_ones && !man_zero;
        k.snan = k.nan && !x[MAN_W-1];
        return k;
    endfunction

    function automatic logic [W-1:0] quiet(input logic [W-1:0] x);
        logic [W-1:0] q;
        q = x;
        if (NAN_QUIET != 0) q[MAN_W-1] = 1'b1;
        return q;
    endfunction

    // Priority chain: NaN > invalid > inf > zero > overflow > underflow.
    function automatic sel_t resolve(input lane_t l, input logic nj);
        sel_t         s;
        logic [W-1:0] inf_ab;
        logic         inv_case;
        s        = '0;
        inf_ab   = {l.a[W-1] ^ l.b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        s.iv     = l.ca.snan | l.cb.snan | l.cc.snan;
        inv_case = (l.ca.inf && l.cb.zero) || (l.cb.inf && l.ca.zero) ||
                   (l.inv && l.cc.inf && ((l.ca.inf && !l.cb.zero) || (l.cb.inf && !l.ca.zero)));
        if (l.ca.nan) begin
            s.sp = 1'b1; s.res = quiet(l.a);
        end else if (l.cb.nan) begin
            s.sp = 1'b1; s.res = quiet(l.b);
        end else if (l.cc.nan) begin
            s.sp = 1'b1; s.res = quiet(l.c);
        end else if (inv_case) begin
            s.sp = 1'b1; s.res = QNAN; s.iv = 1'b1;
        end else if (l.ca.inf || l.cb.inf || l.cc.inf) begin
            s.sp = 1'b1;
            if (l.cc.inf)                  s.res = l.c;
            else if (l.ca.inf && l.cb.inf) s.res = inf_ab;
            else if (l.ca.inf)             s.res = l.a;
            else                           s.res = l.b;
        end else if (l.ca.zero || l.cb.zero) begin
            s.sp = 1'b1; s.res = l.c;
        end else if (l.ovf) begin
            s.sp = 1'b1; s.res = inf_ab; s.ov = 1'b1;
        end else if (l.unf) begin
            s.un = 1'b1;
            if (nj) begin
                s.sp = 1'b1; s.res = l.c;
            end
        end
        return s;
    endfunction

    logic             s1_vld;
    logic             s1_nj;
    lane_t            s1_lane [LANES];
    sel_t             lane_sel [LANES];
    logic [LANES-1:0] mask_nxt;
    logic [W*LANES-1:0] res_nxt;
    logic             ev_inv_nxt, ev_ovf_nxt, ev_unf_nxt;
    logic             out_ev_inv, out_ev_ovf, out_ev_unf;
    logic             s2_adv;
    logic             out_hs;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s2_adv;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        mask_nxt   = '0;
        res_nxt    = '0;
        ev_inv_nxt = 1'b0;
        ev_ovf_nxt = 1'b0;
        ev_unf_nxt = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_sel[i]        = resolve(s1_lane[i], s1_nj);
            mask_nxt[i]        = lane_sel[i].sp;
            res_nxt[i*W +: W]  = lane_sel[i].res;
            ev_inv_nxt         = ev_inv_nxt | lane_sel[i].iv;
            ev_ovf_nxt         = ev_ovf_nxt | lane_sel[i].ov;
            ev_unf_nxt         = ev_unf_nxt | lane_sel[i].un;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld         <= 1'b0;
            s1_nj          <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_lane[i] <= '0;
            out_valid      <= 1'b0;
            spec_mask      <= '0;
            res_spec       <= '0;
            out_ev_inv     <= 1'b0;
            out_ev_ovf     <= 1'b0;
            out_ev_unf     <= 1'b0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_nj <= nj_mode;
                    for (int i = 0; i < LANES; i++) begin
                        s1_lane[i].a   <= operand_a[i*W +: W];
                        s1_lane[i].b   <= operand_b[i*W +: W];
                        s1_lane[i].c   <= operand_c[i*W +: W];
                        s1_lane[i].ca  <= classify(operand_a[i*W +: W]);
                        s1_lane[i].cb  <= classify(operand_b[i*W +: W]);
                        s1_lane[i].cc  <= classify(operand_c[i*W +: W]);
                        s1_lane[i].ovf <= $signed(exp_ab[i*EW +: EW]) > EMAX;
                        s1_lane[i].unf <= $signed(exp_ab[i*EW +: EW]) < EMIN;
                        s1_lane[i].inv <= inv_mask[i];
                    end
                end
            end
            if (s2_adv) begin
                out_valid  <= s1_vld;
                spec_mask  <= s1_vld ? mask_nxt : '0;
                res_spec   <= s1_vld ? res_nxt : '0;
                out_ev_inv <= s1_vld && ev_inv_nxt;
                out_ev_ovf <= s1_vld && ev_ovf_nxt;
                out_ev_unf <= s1_vld && ev_unf_nxt;
            end
            // A new event on the handshake beats a concurrent clear.
            flag_invalid   <= (flag_invalid   && !flag_clr) || (out_hs && out_ev_inv);
            flag_overflow  <= (flag_overflow  && !flag_clr) || (out_hs && out_ev_ovf);
            flag_underflow <= (flag_underflow && !flag_clr) || (out_hs && out_ev_unf);
        end
    end

endmodule

// File: tb/tb_spec_handler_pipe.sv
// Randomised and directed bench for spec_handler_pipe; two instances cover NAN_QUIET=1 and NAN_QUIET=0.
module tb_spec_handler_pipe;
    localparam int LANES = 4;
    localparam int W     = 32;
    localparam int EW    = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, nj_mode, out_ready, flag_clr;
    logic [LANES-1:0]    inv_mask;
    logic [LANES*W-1:0]  operand_a, operand_b, operand_c;
    logic [LANES*EW-1:0] exp_ab;
    logic                in_ready, out_valid, flag_invalid, flag_overflow, flag_underflow;
    logic [LANES-1:0]    spec_mask;
    logic [LANES*W-1:0]  res_spec;
    logic                n_in_ready, n_out_valid, n_flag_invalid, n_flag_overflow, n_flag_underflow;
    logic [LANES-1:0]    n_spec_mask;
    logic [LANES*W-1:0]  n_res_spec;

    spec_handler_pipe #(.EXP_W(8), .MAN_W(23), .LANES(LANES), .NAN_QUIET(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .nj_mode(nj_mode),
        .inv_mask(inv_mask), .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
        .exp_ab(exp_ab), .out_valid(out_valid), .out_ready(out_ready), .spec_mask(spec_mask),
        .res_spec(res_spec), .flag_clr(flag_clr), .flag_invalid(flag_invalid),
        .flag_overflow(flag_overflow), .flag_underflow(flag_underflow));

    spec_handler_pipe #(.EXP_W(8), .MAN_W(23), .LANES(LANES), .NAN_QUIET(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready), .nj_mode(nj_mode),
        .inv_mask(inv_mask), .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
        .exp_ab(exp_ab), .out_valid(n_out_valid), .out_ready(out_ready), .spec_mask(n_spec_mask),
        .res_spec(n_res_spec), .flag_clr(flag_clr), .flag_invalid(n_flag_invalid),
        .flag_overflow(n_flag_overflow), .flag_underflow(n_flag_underflow));

    typedef struct {
        logic [LANES*W-1:0]  a, b, c;
        logic [LANES*EW-1:0] e;
        logic [LANES-1:0]    inv;
        logic                nj;
    } txn_t;

    typedef struct {
        logic [LANES-1:0]   mask;
        logic [LANES*W-1:0] rq, rn;
        logic               iv, ov, un;
        int                 acc;
    } exp_t;

    typedef struct packed {
        logic        sp;
        logic [31:0] r;
        logic        iv, ov, un;
    } lr_t;

    txn_t txq[$];
    exp_t expq[$];
    int   errs = 0;
    int   checks = 0;
    int   gcyc = 0;
    logic [2:0]         mflags = 3'b000;
    logic [LANES-1:0]   last_mask;
    logic [LANES*W-1:0] last_rq, last_rn;

    function automatic bit is_nan(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] != 0; endfunction
    function automatic bit is_inf(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] == 0; endfunction
    function automatic bit is_zero(input logic [31:0] x); return x[30:0] == 0; endfunction
    function automatic bit is_snan(input logic [31:0] x); return is_nan(x) && !x[22]; endfunction

    // Reference: plain IEEE-style reading of the special-case rules, one lane at a time.
    function automatic lr_t model_lane(input logic [31:0] a, b, c, input int e, input bit inv, nj, quiet);
        lr_t         r;
        logic [31:0] inf_ab;
        r      = '0;
        inf_ab = {a[31] ^ b[31], 8'hFF, 23'h0};
        r.iv   = is_snan(a) || is_snan(b) || is_snan(c);
        if (is_nan(a) || is_nan(b) || is_nan(c)) begin
            r.sp = 1;
            r.r  = is_nan(a) ? a : (is_nan(b) ? b : c);
            if (quiet) r.r[22] = 1'b1;
            return r;
        end
        if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)) ||
            (inv && is_inf(c) && ((is_inf(a) && !is_zero(b)) || (is_inf(b) && !is_zero(a))))) begin
            r.sp = 1; r.r = 32'h7FC00000; r.iv = 1;
            return r;
        end
        if (is_inf(a) || is_inf(b) || is_inf(c)) begin
            r.sp = 1;
            r.r  = is_inf(c) ? c : ((is_inf(a) && is_inf(b)) ? inf_ab : (is_inf(a) ? a : b));
            return r;
        end
        if (is_zero(a) || is_zero(b)) begin
            r.sp = 1; r.r = c;
            return r;
        end
        if (e > 127) begin
            r.sp = 1; r.r = inf_ab; r.ov = 1;
            return r;
        end
        if (e < -126) begin
            r.un = 1;
            if (nj) begin r.sp = 1; r.r = c; end
        end
        return r;
    endfunction

    function automatic exp_t predict(input txn_t t);
        exp_t       x;
        lr_t        q, n;
        logic [8:0] ev;
        int         e;
        x.mask = '0; x.rq = '0; x.rn = '0; x.iv = 0; x.ov = 0; x.un = 0; x.acc = 0;
        for (int i = 0; i < LANES; i++) begin
            ev = t.e[i*EW +: EW];
            e  = int'($signed(ev));
            q  = model_lane(t.a[i*W +: W], t.b[i*W +: W], t.c[i*W +: W], e, t.inv[i], t.nj, 1'b1);
            n  = model_lane(t.a[i*W +: W], t.b[i*W +: W], t.c[i*W +: W], e, t.inv[i], t.nj, 1'b0);
            x.mask[i]       = q.sp;
            x.rq[i*W +: W]  = q.r;
            x.rn[i*W +: W]  = n.r;
            x.iv = x.iv | q.iv;
            x.ov = x.ov | q.ov;
            x.un = x.un | q.un;
        end
        return x;
    endfunction

    function automatic logic [31:0] gen_norm();
        logic [31:0] rnd;
        logic [7:0]  ex;
        rnd = $urandom;
        ex  = 8'($urandom_range(1, 254));
        return {rnd[31], ex, rnd[22:0]};
    endfunction

    function automatic logic [31:0] gen_op();
        logic [31:0] rnd;
        rnd = $urandom;
        case ($urandom_range(0, 9))
            0:       return {rnd[31], 31'h0};
            1:       return {rnd[31], 8'hFF, 23'h0};
            2:       return {rnd[31], 8'hFF, 1'b1, rnd[21:0]};
            3:       return {rnd[31], 8'hFF, 1'b0, rnd[21:1], 1'b1};
            4:       return {rnd[31], 8'h00, rnd[22:1], 1'b1};
            default: return gen_norm();
        endcase
    endfunction

    function automatic txn_t gen_txn();
        txn_t t;
        int   e;
        for (int i = 0; i < LANES; i++) begin
            t.a[i*W +: W] = gen_op();
            t.b[i*W +: W] = gen_op();
            t.c[i*W +: W] = gen_op();
            case ($urandom_range(0, 7))
                0: e = -128;
                1: e = -127;
                2: e = -126;
                3: e = 127;
                4: e = 128;
                5: e = $urandom_range(0, 400) - 200;
                default: e = 0;
            endcase
            t.e[i*EW +: EW] = e[EW-1:0];
        end
        t.inv = 4'($urandom);
        t.nj  = 1'($urandom);
        return t;
    endfunction

    function automatic txn_t mk_dir(input logic [31:0] a0, b0, c0, input int e0, input bit inv0, nj);
        txn_t t;
        int   ez;
        ez = 0;
        for (int i = 1; i < LANES; i++) begin
            t.a[i*W +: W]   = gen_norm();
            t.b[i*W +: W]   = gen_norm();
            t.c[i*W +: W]   = gen_norm();
            t.e[i*EW +: EW] = ez[EW-1:0];
        end
        t.a[W-1:0]  = a0;
        t.b[W-1:0]  = b0;
        t.c[W-1:0]  = c0;
        t.e[EW-1:0] = e0[EW-1:0];
        t.inv       = {3'($urandom), inv0};
        t.nj        = nj;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        operand_a = t.a; operand_b = t.b; operand_c = t.c;
        exp_ab = t.e; inv_mask = t.inv; nj_mode = t.nj;
    endtask

    // mode 0: out_ready=1; 1: random ready/gaps/clears; 2: ready pattern 1,0,0,1; 3: ready=1 with flag_clr held.
    task automatic run(input int mode);
        int         cyc;
        int         pat;
        logic       exp_ov, exp_ir;
        logic [2:0] hs_ev;
        exp_t       x;
        logic [63:0] r64;
        cyc = 0;
        pat = 0;
        while ((txq.size() > 0 || expq.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            gcyc++;
            checks++;
            if ({flag_invalid, flag_overflow, flag_underflow} !== mflags ||
                {n_flag_invalid, n_flag_overflow, n_flag_underflow} !== mflags) begin
                errs++;
                $display("FAIL flags: got %b/%b want %b", {flag_invalid, flag_overflow, flag_underflow},
                         {n_flag_invalid, n_flag_overflow, n_flag_underflow}, mflags);
            end
            exp_ov = expq.size() > 0 && gcyc >= expq[0].acc + 2;
            checks++;
            if (out_valid !== exp_ov || n_out_valid !== exp_ov) begin
                errs++;
                $display("FAIL out_valid: got %b/%b want %b", out_valid, n_out_valid, exp_ov);
            end
            case (mode)
                1:       out_ready = 1'($urandom);
                2:       out_ready = (pat % 4 == 0) || (pat % 4 == 3);
                default: out_ready = 1'b1;
            endcase
            pat++;
            flag_clr = (mode == 3) || (mode == 1 && $urandom_range(0, 7) == 0);
            #1;
            exp_ir = !(expq.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_ir || n_in_ready !== exp_ir) begin
                errs++;
                $display("FAIL in_ready: got %b/%b want %b", in_ready, n_in_ready, exp_ir);
            end
            hs_ev = 3'b000;
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errs++;
                    $display("FAIL spurious_output: got out_valid=1 want nothing pending");
                end else begin
                    x = expq.pop_front();
                    hs_ev = {x.iv, x.ov, x.un};
                    last_mask = spec_mask;
                    last_rq = res_spec;
                    last_rn = n_res_spec;
                    if (spec_mask !== x.mask || n_spec_mask !== x.mask || res_spec !== x.rq || n_res_spec !== x.rn) begin
                        errs++;
                        $display("FAIL out_data: got mask=%h res=%h resn=%h want mask=%h res=%h resn=%h",
                                 spec_mask, res_spec, n_res_spec, x.mask, x.rq, x.rn);
                    end
                end
            end
            mflags = (mflags & ~{3{flag_clr}}) | hs_ev;
            if (txq.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                drive(txq[0]);
                if (in_ready) begin
                    x = predict(txq.pop_front());
                    x.acc = gcyc;
                    expq.push_back(x);
                end
            end else begin
                in_valid  = 1'b0;
                operand_a = {$urandom, $urandom, $urandom, $urandom};
                operand_b = {$urandom, $urandom, $urandom, $urandom};
                r64       = {$urandom, $urandom};
                exp_ab    = r64[LANES*EW-1:0];
            end
        end
        checks++;
        if (cyc >= 4000) begin
            errs++;
            $display("FAIL timeout: got %0d pending want 0", txq.size() + expq.size());
            txq.delete();
            expq.delete();
        end
    endtask

    task automatic clear_flags();
        @(negedge clk);
        in_valid = 1'b0;
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        mflags = 3'b000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
        nj_mode = 1'b0; inv_mask = '0; exp_ab = '0;
        operand_a = '0; operand_b = '0; operand_c = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || spec_mask !== '0 || res_spec !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got v=%b m=%h r=%h want 0", out_valid, spec_mask, res_spec);
        end
        checks++;
        if ({flag_invalid, flag_overflow, flag_underflow} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags: got %b want 000", {flag_invalid, flag_overflow, flag_underflow});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        mflags = 3'b000;
    endtask

    task automatic test_directed();
        logic [31:0] da[7]  = '{32'h7F800000, 32'h7F800001, 32'hFF800000, 32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        logic [31:0] db[7]  = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        logic [31:0] dc[7]  = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000, 32'h40000000, 32'h40000000, 32'h40000000};
        int          de[7]  = '{0, 0, 0, 0, 128, -127, -127};
        bit          dinv[7] = '{0, 0, 0, 1, 0, 0, 0};
        bit          dnj[7]  = '{0, 0, 0, 0, 0, 1, 0};
        logic        wm[7]  = '{1, 1, 1, 1, 1, 1, 0};
        logic [31:0] wq[7]  = '{32'h7FC00000, 32'h7FC00001, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h40000000, 32'h0};
        logic [31:0] wn[7]  = '{32'h7FC00000, 32'h7F800001, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h40000000, 32'h0};
        logic [2:0]  wf[7]  = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001};
        for (int k = 0; k < 7; k++) begin
            clear_flags();
            txq.push_back(mk_dir(da[k], db[k], dc[k], de[k], dinv[k], dnj[k]));
            run(0);
            @(negedge clk);
            checks++;
            if (last_mask[0] !== wm[k] || last_rq[31:0] !== wq[k] || last_rn[31:0] !== wn[k]) begin
                errs++;
                $display("FAIL directed%0d_lane0: got m=%b r=%h rn=%h want m=%b r=%h rn=%h",
                         k, last_mask[0], last_rq[31:0], last_rn[31:0], wm[k], wq[k], wn[k]);
            end
            checks++;
            if ({flag_invalid, flag_overflow, flag_underflow} !== wf[k]) begin
                errs++;
                $display("FAIL directed%0d_flags: got %b want %b", k, {flag_invalid, flag_overflow, flag_underflow}, wf[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) txq.push_back(gen_txn());
        run(1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) txq.push_back(gen_txn());
        run(2);
        for (int k = 0; k < 8; k++) txq.push_back(gen_txn());
        run(0);
    endtask

    task automatic test_reset_midstream();
        clear_flags();
        txq.push_back(mk_dir(32'h3F800000, 32'h3F800000, 32'h40000000, 128, 0, 0));
        run(0);
        @(negedge clk);
        checks++;
        if (flag_overflow !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_flag: got %b want 1", flag_overflow);
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(gen_txn());
        @(negedge clk);
        drive(gen_txn());
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL two_in_flight: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || {flag_invalid, flag_overflow, flag_underflow} !== 3'b000 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL midstream_reset: got v=%b f=%b rdy=%b want v=0 f=000 rdy=1",
                     out_valid, {flag_invalid, flag_overflow, flag_underflow}, in_ready);
        end
        rst_n = 1'b1;
        expq.delete();
        mflags = 3'b000;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL dropped_data: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_clr_overflow();
        clear_flags();
        txq.push_back(mk_dir(32'h3F800000, 32'h3F800000, 32'h40000000, 128, 0, 0));
        run(3);
        @(negedge clk);
        checks++;
        if (flag_overflow !== 1'b1) begin
            errs++;
            $display("FAIL clr_vs_overflow: got %b want 1", flag_overflow);
        end
        flag_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        test_clr_overflow();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
